// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the 8-point FFT datapath.
//   - Datapath widths: the external word width, the input/output fractional
//     bits and the internal width IW.
//   - The W8 twiddle constants in Q1.(WIDTH-2).
//   - The complex sample struct, the state and twiddle-select enums, and the
//     bit-reverse load order.
//   - Helpers: twiddle multiply, twiddle rounding, and output round/saturate.
package fft_pkg;

    localparam int FFT_WIDTH = 16;
    localparam int FFT_Q_IN  = 12;
    localparam int FFT_Q_OUT = 11;

    // Four guard bits cover the 8x growth of an unscaled 8-point transform
    // plus the sqrt(2) peak contributed by the odd twiddles.
    localparam int IW = FFT_WIDTH + 4;

    // A twiddle product is IW x WIDTH bits. One extra bit holds the sum of
    // two products in a complex multiply.
    localparam int PW = IW + FFT_WIDTH + 1;

    localparam int TW_FRAC = FFT_WIDTH - 2;

    localparam logic signed [FFT_WIDTH-1:0] W8_1_RE = FFT_WIDTH'(11585);
    localparam logic signed [FFT_WIDTH-1:0] W8_1_IM = -W8_1_RE;
    localparam logic signed [FFT_WIDTH-1:0] W8_3_RE = -W8_1_RE;
    localparam logic signed [FFT_WIDTH-1:0] W8_3_IM = -W8_1_RE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_DONE
    } fft_state_t;

    // TW_2 is -j and TW_0 is 1. The butterfly handles both as swaps and
    // negations, so neither one uses a multiplier.
    typedef enum logic [1:0] {
        TW_0,
        TW_1,
        TW_2,
        TW_3
    } tw_sel_t;

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_t;

    localparam logic [2:0] BITREV [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    // Full-precision product of a data word and a twiddle constant.
    function automatic logic signed [PW-1:0] tw_mul(
        input logic signed [IW-1:0]        x,
        input logic signed [FFT_WIDTH-1:0] w
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] we;
        xe = PW'(x);
        we = PW'(w);
        return xe * we;
    endfunction

    // Brings a product back to Q_inputs scaling, rounding half-up.
    function automatic logic signed [IW-1:0] tw_round(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + (PW'(1) <<< (TW_FRAC - 1))) >>> TW_FRAC;
        return r[IW-1:0];
    endfunction

    // Drops `shift` fractional bits with round-half-up. Then clamps to the
    // signed output word range. One extra bit of headroom lets the rounding
    // add run without wrapping.
    function automatic logic signed [FFT_WIDTH-1:0] round_sat(
        input logic signed [IW-1:0] v,
        input int                   shift
    );
        logic signed [IW:0] t;
        logic signed [IW:0] sat_max;
        logic signed [IW:0] sat_min;
        t = (IW+1)'(v);
        if (shift > 0) begin
            t = (t + ((IW+1)'(1) <<< (shift - 1))) >>> shift;
        end
        sat_max = (IW+1)'((1 <<< (FFT_WIDTH - 1)) - 1);
        sat_min = ~sat_max;
        if (t > sat_max) begin
            return sat_max[FFT_WIDTH-1:0];
        end else if (t < sat_min) begin
            return sat_min[FFT_WIDTH-1:0];
        end else begin
            return t[FFT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly
// One radix-2 DIT butterfly: a_out = a + W*b, b_out = a - W*b.
// Ports:
//   a, b          in   complex operands (IW-bit re/im)
//   tw_sel        in   twiddle select: W8^0, W8^1, W8^2 (-j), W8^3
//   a_out, b_out  out  butterfly results, with no scaling
module fft_butterfly
    import fft_pkg::*;
(
    input  cplx_t   a,
    input  cplx_t   b,
    input  tw_sel_t tw_sel,
    output cplx_t   a_out,
    output cplx_t   b_out
);

    cplx_t                wb;
    logic signed [PW-1:0] prod_re;
    logic signed [PW-1:0] prod_im;

    // Forms W*b.
    // W8^1 and W8^3 need real multiplies. Each component is rounded once,
    // after the full-precision sum.
    // -j*(br + j*bi) = bi - j*br, so W8^2 is a swap plus a negation.
    always_comb begin
        prod_re = '0;
        prod_im = '0;
        wb      = b;
        case (tw_sel)
            TW_0: begin
                wb = b;
            end
            TW_1: begin
                prod_re = tw_mul(b.re, W8_1_RE) - tw_mul(b.im, W8_1_IM);
                prod_im = tw_mul(b.re, W8_1_IM) + tw_mul(b.im, W8_1_RE);
                wb.re   = tw_round(prod_re);
                wb.im   = tw_round(prod_im);
            end
            TW_2: begin
                wb.re = b.im;
                wb.im = -b.re;
            end
            TW_3: begin
                prod_re = tw_mul(b.re, W8_3_RE) - tw_mul(b.im, W8_3_IM);
                prod_im = tw_mul(b.re, W8_3_IM) + tw_mul(b.im, W8_3_RE);
                wb.re   = tw_round(prod_re);
                wb.im   = tw_round(prod_im);
            end
            default: begin
                wb = b;
            end
        endcase
    end

    // Sum and difference. IW is wide enough that neither can wrap.
    assign a_out = '{re: a.re + wb.re, im: a.im + wb.im};
    assign b_out = '{re: a.re - wb.re, im: a.im - wb.im};

endmodule

// File: rtl/fft_8point_top.sv
// fft_8point_top
// An 8-point complex FFT: radix-2 DIT, three clocked stages.
// Four butterflies are reused across the stages through an index mux.
// Ports:
//   clk                             in   rising-edge clock
//   rst_n                           in   synchronous reset, active-high
//   start                           in   one-cycle request; inputs are sampled on the same edge
//   x_in_k_real/x_in_k_imag (k=0..7)   in   time-domain samples, Q_inputs
//   x_out_k_real/x_out_k_imag (k=0..7) out  frequency bins X[k], Q_outputs, natural order
//   valid_out                       out  outputs hold a completed result
//   done                            out  one-cycle completion pulse
// Note: the internal width comes from fft_pkg. WIDTH must match FFT_WIDTH.
module fft_8point_top
    import fft_pkg::*;
#(
    parameter int WIDTH     = FFT_WIDTH,
    parameter int Q_inputs  = FFT_Q_IN,
    parameter int Q_outputs = FFT_Q_OUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in_0_real,
    input  logic [WIDTH-1:0] x_in_0_imag,
    input  logic [WIDTH-1:0] x_in_1_real,
    input  logic [WIDTH-1:0] x_in_1_imag,
    input  logic [WIDTH-1:0] x_in_2_real,
    input  logic [WIDTH-1:0] x_in_2_imag,
    input  logic [WIDTH-1:0] x_in_3_real,
    input  logic [WIDTH-1:0] x_in_3_imag,
    input  logic [WIDTH-1:0] x_in_4_real,
    input  logic [WIDTH-1:0] x_in_4_imag,
    input  logic [WIDTH-1:0] x_in_5_real,
    input  logic [WIDTH-1:0] x_in_5_imag,
    input  logic [WIDTH-1:0] x_in_6_real,
    input  logic [WIDTH-1:0] x_in_6_imag,
    input  logic [WIDTH-1:0] x_in_7_real,
    input  logic [WIDTH-1:0] x_in_7_imag,
    output logic [WIDTH-1:0] x_out_0_real,
    output logic [WIDTH-1:0] x_out_0_imag,
    output logic [WIDTH-1:0] x_out_1_real,
    output logic [WIDTH-1:0] x_out_1_imag,
    output logic [WIDTH-1:0] x_out_2_real,
    output logic [WIDTH-1:0] x_out_2_imag,
    output logic [WIDTH-1:0] x_out_3_real,
    output logic [WIDTH-1:0] x_out_3_imag,
    output logic [WIDTH-1:0] x_out_4_real,
    output logic [WIDTH-1:0] x_out_4_imag,
    output logic [WIDTH-1:0] x_out_5_real,
    output logic [WIDTH-1:0] x_out_5_imag,
    output logic [WIDTH-1:0] x_out_6_real,
    output logic [WIDTH-1:0] x_out_6_imag,
    output logic [WIDTH-1:0] x_out_7_real,
    output logic [WIDTH-1:0] x_out_7_imag,
    output logic             valid_out,
    output logic             done
);

    localparam int OUT_SHIFT = Q_inputs - Q_outputs;

    // Butterfly pairings per stage, as indices into the bit-reversed working set.
    // In stage 3, butterfly i pairs bins i and i+4. That is what lets the output
    // write below use constant indices.
    localparam logic [2:0] S1_A [4] = '{3'd0, 3'd2, 3'd4, 3'd6};
    localparam logic [2:0] S1_B [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
    localparam logic [2:0] S2_A [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
    localparam logic [2:0] S2_B [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
    localparam logic [2:0] S3_A [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    localparam logic [2:0] S3_B [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    localparam tw_sel_t    S2_TW [4] = '{TW_0, TW_2, TW_0, TW_2};
    localparam tw_sel_t    S3_TW [4] = '{TW_0, TW_1, TW_2, TW_3};

    fft_state_t              state_q, state_d;
    cplx_t                   data_q [8];
    cplx_t                   data_d [8];
    logic        [WIDTH-1:0] out_re_q [8];
    logic        [WIDTH-1:0] out_re_d [8];
    logic        [WIDTH-1:0] out_im_q [8];
    logic        [WIDTH-1:0] out_im_d [8];
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    logic signed [WIDTH-1:0] x_re [8];
    logic signed [WIDTH-1:0] x_im [8];

    logic        [2:0]       a_idx [4];
    logic        [2:0]       b_idx [4];
    tw_sel_t                 tw    [4];
    cplx_t                   bf_a     [4];
    cplx_t                   bf_b     [4];
    cplx_t                   bf_a_out [4];
    cplx_t                   bf_b_out [4];

    assign x_re[0] = x_in_0_real;
    assign x_im[0] = x_in_0_imag;
    assign x_re[1] = x_in_1_real;
    assign x_im[1] = x_in_1_imag;
    assign x_re[2] = x_in_2_real;
    assign x_im[2] = x_in_2_imag;
    assign x_re[3] = x_in_3_real;
    assign x_im[3] = x_in_3_imag;
    assign x_re[4] = x_in_4_real;
    assign x_im[4] = x_in_4_imag;
    assign x_re[5] = x_in_5_real;
    assign x_im[5] = x_in_5_imag;
    assign x_re[6] = x_in_6_real;
    assign x_im[6] = x_in_6_imag;
    assign x_re[7] = x_in_7_real;
    assign x_im[7] = x_in_7_imag;

    // Chooses the operand pairs and twiddles for the current stage. Stage 1
    // is the default, so the butterflies see stable inputs in the other states.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_idx[i] = S1_A[i];
            b_idx[i] = S1_B[i];
            tw[i]    = TW_0;
            if (state_q == ST_S2) begin
                a_idx[i] = S2_A[i];
                b_idx[i] = S2_B[i];
                tw[i]    = S2_TW[i];
            end else if (state_q == ST_S3) begin
                a_idx[i] = S3_A[i];
                b_idx[i] = S3_B[i];
                tw[i]    = S3_TW[i];
            end
            bf_a[i] = data_q[a_idx[i]];
            bf_b[i] = data_q[b_idx[i]];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bf
        fft_butterfly u_bf (
            .a      (bf_a[g]),
            .b      (bf_b[g]),
            .tw_sel (tw[g]),
            .a_out  (bf_a_out[g]),
            .b_out  (bf_b_out[g])
        );
    end

    // Next-state logic for the sequence IDLE -> S1 -> S2 -> S3 -> DONE.
    // An accepted start loads the samples in bit-reversed order and clears
    // valid. S1 and S2 write butterfly results back in place. S3 sends the
    // final butterfly results through round/saturate into the output
    // registers. A start outside IDLE is ignored.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) begin
                        data_d[i].re = IW'(x_re[BITREV[i]]);
                        data_d[i].im = IW'(x_im[BITREV[i]]);
                    end
                    valid_d = 1'b0;
                    state_d = ST_S1;
                end
            end
            ST_S1, ST_S2: begin
                for (int i = 0; i < 4; i++) begin
                    data_d[a_idx[i]] = bf_a_out[i];
                    data_d[b_idx[i]] = bf_b_out[i];
                end
                state_d = (state_q == ST_S1) ? ST_S2 : ST_S3;
            end
            ST_S3: begin
                for (int i = 0; i < 4; i++) begin
                    out_re_d[i]     = round_sat(bf_a_out[i].re, OUT_SHIFT);
                    out_im_d[i]     = round_sat(bf_a_out[i].im, OUT_SHIFT);
                    out_re_d[i + 4] = round_sat(bf_b_out[i].re, OUT_SHIFT);
                    out_im_d[i + 4] = round_sat(bf_b_out[i].im, OUT_SHIFT);
                end
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset takes priority over everything. A
    // reset mid-transform discards the work in flight, so no done pulse follows.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                data_q[i]   <= '0;
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            data_q   <= data_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign valid_out    = valid_q;
    assign done         = done_q;
    assign x_out_0_real = out_re_q[0];
    assign x_out_0_imag = out_im_q[0];
    assign x_out_1_real = out_re_q[1];
    assign x_out_1_imag = out_im_q[1];
    assign x_out_2_real = out_re_q[2];
    assign x_out_2_imag = out_im_q[2];
    assign x_out_3_real = out_re_q[3];
    assign x_out_3_imag = out_im_q[3];
    assign x_out_4_real = out_re_q[4];
    assign x_out_4_imag = out_im_q[4];
    assign x_out_5_real = out_re_q[5];
    assign x_out_5_imag = out_im_q[5];
    assign x_out_6_real = out_re_q[6];
    assign x_out_6_imag = out_im_q[6];
    assign x_out_7_real = out_re_q[7];
    assign x_out_7_imag = out_im_q[7];

endmodule

// File: tb/tb_fft_8point_top.sv
// tb_fft_8point_top
// Directed checks of fft_8point_top:
//   - reset state
//   - impulse, DC, alternating, tone and saturation vectors
//   - start/done handshake and output hold
//   - reset abort, and reset-over-start priority
//   - one pseudo-random vector against a floating-point DFT
module tb_fft_8point_top;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic signed [15:0] x_re [8];
    logic signed [15:0] x_im [8];
    logic signed [15:0] y_re [8];
    logic signed [15:0] y_im [8];
    logic valid_out;
    logic done;

    int total = 0;
    int bad   = 0;
    int vec_re [8];
    int vec_im [8];
    int exp_re [8];
    int exp_im [8];

    always #5 clk = ~clk;

    fft_8point_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_in_0_real  (x_re[0]), .x_in_0_imag (x_im[0]),
        .x_in_1_real  (x_re[1]), .x_in_1_imag (x_im[1]),
        .x_in_2_real  (x_re[2]), .x_in_2_imag (x_im[2]),
        .x_in_3_real  (x_re[3]), .x_in_3_imag (x_im[3]),
        .x_in_4_real  (x_re[4]), .x_in_4_imag (x_im[4]),
        .x_in_5_real  (x_re[5]), .x_in_5_imag (x_im[5]),
        .x_in_6_real  (x_re[6]), .x_in_6_imag (x_im[6]),
        .x_in_7_real  (x_re[7]), .x_in_7_imag (x_im[7]),
        .x_out_0_real (y_re[0]), .x_out_0_imag (y_im[0]),
        .x_out_1_real (y_re[1]), .x_out_1_imag (y_im[1]),
        .x_out_2_real (y_re[2]), .x_out_2_imag (y_im[2]),
        .x_out_3_real (y_re[3]), .x_out_3_imag (y_im[3]),
        .x_out_4_real (y_re[4]), .x_out_4_imag (y_im[4]),
        .x_out_5_real (y_re[5]), .x_out_5_imag (y_im[5]),
        .x_out_6_real (y_re[6]), .x_out_6_imag (y_im[6]),
        .x_out_7_real (y_re[7]), .x_out_7_imag (y_im[7]),
        .valid_out    (valid_out),
        .done         (done)
    );

    // Compares one observed value with its expected value, within tol.
    task automatic checkOutput(input string tag, input int got, input int want, input int tol);
        int diff;
        total++;
        diff = got - want;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    // Pulses start with vec_re/vec_im on the inputs, then scrambles the
    // inputs so that the DUT has to have captured them on the start edge.
    task automatic applyStimulus();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            x_re[i] = 16'(vec_re[i]);
            x_im[i] = 16'(vec_im[i]);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x_re[i] = 16'($urandom);
            x_im[i] = 16'($urandom);
        end
    endtask

    // Waits, with a bound, for done and returns the number of edges seen.
    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < 10);
    endtask

    task automatic checkBins(input string tag, input int tol);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s X%0d re", tag, k), int'(y_re[k]), exp_re[k], tol);
            checkOutput($sformatf("%s X%0d im", tag, k), int'(y_im[k]), exp_im[k], tol);
        end
    endtask

    task automatic runFft(input string tag, input int tol);
        int cycles;
        applyStimulus();
        waitDone(cycles);
        checkOutput({tag, " latency"}, cycles, 3, 0);
        checkOutput({tag, " valid"}, int'(valid_out), 1, 0);
        checkBins(tag, tol);
        @(posedge clk);
        #1;
        checkOutput({tag, " done width"}, int'(done), 0, 0);
    endtask

    task automatic clearVec();
        for (int i = 0; i < 8; i++) begin
            vec_re[i] = 0;
            vec_im[i] = 0;
            exp_re[i] = 0;
            exp_im[i] = 0;
        end
    endtask

    // Counts done pulses over a window in which none should appear.
    task automatic countDone(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        int drops;
        int changed;
        int cycles;
        real sr;
        real si;
        real ang;

        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x_re[i] = '0;
            x_im[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        clearVec();
        checkBins("reset", 0);
        checkOutput("reset valid", int'(valid_out), 0, 0);
        checkOutput("reset done", int'(done), 0, 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Impulse: every bin is 1.0 = 2048 at Q11.
        clearVec();
        vec_re[0] = 4096;
        for (int k = 0; k < 8; k++) exp_re[k] = 2048;
        runFft("impulse", 0);

        // DC: X0 = 8.0 = 16384.
        clearVec();
        for (int i = 0; i < 8; i++) vec_re[i] = 4096;
        exp_re[0] = 16384;
        runFft("dc", 0);

        // Alternating +/-1.0: X4 = 16384.
        clearVec();
        for (int i = 0; i < 8; i++) vec_re[i] = (i % 2 == 1) ? -4096 : 4096;
        exp_re[4] = 16384;
        runFft("alt", 0);

        // Tone e^(j2*pi*n/8): X1 is about 16384. Twiddle rounding allows a few LSB.
        clearVec();
        vec_re = '{4096, 2896, 0, -2896, -4096, -2896, 0, 2896};
        vec_im = '{0, 2896, 4096, 2896, 0, -2896, -4096, -2896};
        exp_re[1] = 16384;
        runFft("tone", 2);

        // All 2.0: X0 = 16.0 overflows Q4.11 and clamps.
        clearVec();
        for (int i = 0; i < 8; i++) vec_re[i] = 8192;
        exp_re[0] = 32767;
        runFft("sat", 0);

        // Handshake: a start re-pulsed during S2 carries DC data and must be ignored.
        clearVec();
        vec_re[0] = 4096;
        for (int k = 0; k < 8; k++) exp_re[k] = 2048;
        applyStimulus();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) x_re[i] = 16'sd4096;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("hs early done", int'(done), 0, 0);
        @(posedge clk);
        #1;
        checkOutput("hs done", int'(done), 1, 0);
        checkBins("hs", 0);
        @(posedge clk);
        #1;
        checkOutput("hs done width", int'(done), 0, 0);
        cnt = 0;
        drops = 0;
        changed = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
            if (!valid_out) drops++;
            for (int k = 0; k < 8; k++) begin
                if (int'(y_re[k]) != exp_re[k] || int'(y_im[k]) != exp_im[k]) changed++;
            end
        end
        checkOutput("hs extra done", cnt, 0, 0);
        checkOutput("hs valid held", drops, 0, 0);
        checkOutput("hs outputs held", changed, 0, 0);
        clearVec();
        for (int i = 0; i < 8; i++) vec_re[i] = 4096;
        exp_re[0] = 16384;
        applyStimulus();
        checkOutput("hs valid cleared", int'(valid_out), 0, 0);
        waitDone(cycles);
        checkOutput("hs2 latency", cycles, 3, 0);
        checkBins("hs2", 0);

        // Reset while in S2 aborts the transform: zeroed outputs and no done.
        clearVec();
        for (int i = 0; i < 8; i++) vec_re[i] = 4096;
        @(posedge clk);
        applyStimulus();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearVec();
        checkBins("abort", 0);
        checkOutput("abort valid", int'(valid_out), 0, 0);
        checkOutput("abort done", int'(done), 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        countDone(8, cnt);
        checkOutput("abort no done", cnt, 0, 0);

        // Reset on the same edge as start: the start is lost.
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 8; i++) x_re[i] = 16'sd4096;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        countDone(8, cnt);
        checkOutput("rst over start done", cnt, 0, 0);
        checkOutput("rst over start valid", int'(valid_out), 0, 0);

        // Pseudo-random vector with |x| <= 1.0, compared with a floating-point
        // DFT within 0.1 (about 204 LSB at Q11).
        for (int i = 0; i < 8; i++) begin
            vec_re[i] = int'($urandom_range(8192)) - 4096;
            vec_im[i] = int'($urandom_range(8192)) - 4096;
        end
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                ang = -2.0 * PI * real'(k * n) / 8.0;
                sr = sr + real'(vec_re[n]) * $cos(ang) - real'(vec_im[n]) * $sin(ang);
                si = si + real'(vec_re[n]) * $sin(ang) + real'(vec_im[n]) * $cos(ang);
            end
            exp_re[k] = int'(sr / 2.0);
            exp_im[k] = int'(si / 2.0);
        end
        runFft("random", 204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
